crc_frame_sequencer: RTL and testbench

Sequences a bit-serial CRC engine (crc_static / crc_dynamic style: serial data bit plus enable) from a byte stream, such as UART receive bytes.
- Accepts bytes over a valid/ready handshake and clears the engine at frame start.
- Shifts each byte into the engine one bit per clock, waits for the engine to settle after the last byte, then captures and presents the frame CRC.
- Replaces the free-running parallel_to_serial path so that frame boundaries are explicit.

---
 rtl/crc_frame_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_crc_frame_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_sequencer.sv
// -----------------------------------------------------------------------------
// crc_frame_sequencer
//
// Drives a bit-serial CRC engine (serial data bit + enable) from a byte stream
// with explicit frame boundaries. The first byte accepted opens a frame and
// clears the engine. Each byte is shifted in one bit per clock. After the byte
// flagged last, the sequencer waits SETTLE_CYCLES idle cycles for the engine
// output to settle. It then captures the CRC and pulses result_valid.
//
// Optional feature (macro CRC_CHECK_EN): after the result pulse, CRC_SIZE/8
// further bytes are accepted, assembled MSB-first and compared to the result.
// The outcome appears on crc_ok / crc_ok_valid.
//
// Parameters:
//   CRC_SIZE      width of crc_value / result (multiple of 8 with CRC_CHECK_EN)
//   MSB_FIRST     1: shift bit7 first, 0: shift bit0 first
//   SETTLE_CYCLES idle cycles (1..7) between last shifted bit and capture
//
// Ports:
//   clk           system clock
//   rst           asynchronous reset, active-low
//   byte_valid    byte_data/byte_last valid
//   byte_data     input byte
//   byte_last     byte is the final data byte of the frame
//   byte_ready    sequencer accepts a byte this cycle
//   abort         drop the current frame (ignored in IDLE)
//   crc_clear     one-cycle engine clear request
//   crc_serial    data bit to the engine
//   crc_enable    engine shifts crc_serial this cycle
//   crc_value     engine's current CRC
//   result        captured frame CRC, held until next capture
//   result_valid  one-cycle pulse when result updates
//   busy          high in every state except IDLE
//   crc_ok        (CRC_CHECK_EN) received CRC matched result
//   crc_ok_valid  (CRC_CHECK_EN) one-cycle pulse when crc_ok is decided
// -----------------------------------------------------------------------------
module crc_frame_sequencer #(
  parameter int CRC_SIZE      = 16,
  parameter bit MSB_FIRST     = 1'b1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  input  logic                byte_last,
  output logic                byte_ready,
  input  logic                abort,
  output logic                crc_clear,
  output logic                crc_serial,
  output logic                crc_enable,
  input  logic [CRC_SIZE-1:0] crc_value,
  output logic [CRC_SIZE-1:0] result,
  output logic                result_valid,
`ifdef CRC_CHECK_EN
  output logic                crc_ok,
  output logic                crc_ok_valid,
`endif
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_WAIT,
    S_SETTLE,
    S_DONE
`ifdef CRC_CHECK_EN
    ,
    S_CHECK,
    S_OK_OUT
`endif
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    byte_q;
  logic          last_q;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_pos;
  logic [2:0]    settle_cnt;
  logic          capture;
  logic          xfer;

`ifdef CRC_CHECK_EN
  localparam int CHK_BYTES = CRC_SIZE / 8;
  localparam int CHK_W     = (CHK_BYTES > 1) ? $clog2(CHK_BYTES) : 1;

  logic [CHK_W-1:0]    chk_cnt;
  logic [CRC_SIZE-1:0] chk_acc;
  logic [CRC_SIZE-1:0] chk_next;
  logic                chk_final;

  // Older bytes move toward the MSB; the truncating cast keeps CRC_SIZE bits.
  assign chk_next  = CRC_SIZE'({chk_acc, byte_data});
  assign chk_final = (chk_cnt == CHK_W'(CHK_BYTES - 1));
`endif

  assign xfer = byte_valid & byte_ready;
  assign busy = (state != S_IDLE);

  // For 3-bit indices, 7-i equals ~i.
  assign bit_pos = MSB_FIRST ? ~bit_idx : bit_idx;

  always_comb begin
    state_nxt    = state;
    byte_ready   = 1'b0;
    crc_clear    = 1'b0;
    crc_serial   = 1'b0;
    crc_enable   = 1'b0;
    result_valid = 1'b0;
    capture      = 1'b0;
`ifdef CRC_CHECK_EN
    crc_ok_valid = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        // State is already IDLE during reset; rst only masks the handshake.
        byte_ready = rst;
        if (byte_valid) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        crc_clear = 1'b1;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        crc_enable = 1'b1;
        crc_serial = byte_q[bit_pos];
        if (bit_idx == 3'd7) begin
          if (last_q) begin
            state_nxt = S_SETTLE;
          end else begin
            // Accepting on the final bit keeps crc_enable high across bytes.
            byte_ready = 1'b1;
            state_nxt  = byte_valid ? S_SHIFT : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = S_SHIFT;
      end
      S_SETTLE: begin
        if (settle_cnt == 3'(SETTLE_CYCLES - 1)) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        result_valid = 1'b1;
`ifdef CRC_CHECK_EN
        state_nxt    = S_CHECK;
`else
        state_nxt    = S_IDLE;
`endif
      end
`ifdef CRC_CHECK_EN
      S_CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid && chk_final) state_nxt = S_OK_OUT;
      end
      S_OK_OUT: begin
        crc_ok_valid = 1'b1;
        state_nxt    = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase

    // Abort wins over everything, including a byte accepted this cycle.
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      capture   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      bit_idx    <= 3'd0;
      settle_cnt <= 3'd0;
      result     <= '0;
    end else begin
      state      <= state_nxt;
      // Wraps 7->0 on its own, so gapless bytes restart at bit 0.
      bit_idx    <= (state == S_SHIFT) ? bit_idx + 3'd1 : 3'd0;
      settle_cnt <= (state == S_SETTLE) ? settle_cnt + 3'd1 : 3'd0;
      if (capture) result <= crc_value;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      byte_q <= byte_data;
      last_q <= byte_last;
    end
  end

`ifdef CRC_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_cnt <= '0;
      crc_ok  <= 1'b0;
    end else begin
      if (state == S_CLEAR) crc_ok <= 1'b0;
      if (state == S_DONE) begin
        chk_cnt <= '0;
      end else if ((state == S_CHECK) && xfer) begin
        chk_cnt <= chk_cnt + CHK_W'(1);
        if (chk_final && !abort) crc_ok <= (chk_next == result);
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state == S_CHECK) && xfer) chk_acc <= chk_next;
  end
`endif

endmodule

// File: tb/tb_crc_frame_sequencer.sv
module tb_crc_frame_sequencer;

  logic        clk;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready;
  logic        abort;
  logic        crc_clear;
  logic        crc_serial;
  logic        crc_enable;
  logic [15:0] crc_value;
  logic [15:0] result;
  logic        result_valid;
  logic        busy;
`ifdef CRC_CHECK_EN
  logic        crc_ok;
  logic        crc_ok_valid;
`endif

  crc_frame_sequencer #(
    .CRC_SIZE(16),
    .MSB_FIRST(1'b1),
    .SETTLE_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_last(byte_last),
    .byte_ready(byte_ready),
    .abort(abort),
    .crc_clear(crc_clear),
    .crc_serial(crc_serial),
    .crc_enable(crc_enable),
    .crc_value(crc_value),
    .result(result),
    .result_valid(result_valid),
`ifdef CRC_CHECK_EN
    .crc_ok(crc_ok),
    .crc_ok_valid(crc_ok_valid),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CRC-16/CCITT-FALSE serial engine, MSB first.
  logic [15:0] eng = 16'h0000;
  always @(posedge clk) begin
    if (crc_clear)       eng <= 16'hFFFF;
    else if (crc_enable) eng <= {eng[14:0], 1'b0} ^ ((eng[15] ^ crc_serial) ? 16'h1021 : 16'h0000);
  end
  assign crc_value = eng;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] exp_q[$];
  logic        ok_q[$];

  int rv_count   = 0;
  int en_total   = 0;
  int max_run    = 0;
  int run        = 0;
  int clr_cnt    = 0;
  int clr_en_cnt = 0;
  logic prev_en  = 1'b0;
  logic prev_clr = 1'b0;

  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (result_valid) begin
      rv_count++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result_valid: result %h, required no pulse", result);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("result", {16'h0, result}, {16'h0, e});
      end
    end
`ifdef CRC_CHECK_EN
    if (crc_ok_valid) begin
      if (ok_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_crc_ok_valid: crc_ok %b, required no pulse", crc_ok);
      end else begin
        logic eo;
        eo = ok_q.pop_front();
        check("crc_ok", {31'h0, crc_ok}, {31'h0, eo});
      end
    end
`endif
    if (crc_enable) begin
      run++;
      en_total++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (crc_clear) clr_cnt++;
    if (crc_enable && !prev_en && prev_clr) clr_en_cnt++;
    prev_en  = crc_enable;
    prev_clr = crc_clear;
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic l);
    logic got;
    got        = 1'b0;
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = l;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      got = byte_ready;
      @(posedge clk);
      #1;
      if (got) break;
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_accept_timeout: byte %h not accepted, required acceptance", d);
    end
  endtask

  task automatic send_msg(input int gap);
    for (int i = 0; i < 9; i++) begin
      send_byte(msg[i], (i == 8));
      if (gap > 0 && i < 8) repeat (gap + 8) @(posedge clk);
      if (gap > 0 && i < 8) #1;
    end
  endtask

  task automatic wait_result();
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL result_timeout: no result_valid, required one");
    end
  endtask

  // With the check feature every frame must be followed by its CRC bytes.
  task automatic finish_frame(input logic [15:0] crc_bytes, input logic exp_ok);
`ifdef CRC_CHECK_EN
    logic seen;
    seen = 1'b0;
    ok_q.push_back(exp_ok);
    send_byte(crc_bytes[15:8], 1'b0);
    send_byte(crc_bytes[7:0], 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (crc_ok_valid) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL crc_ok_timeout: no crc_ok_valid, required one");
    end
`else
    if (crc_bytes == 16'h0 && exp_ok) $display("note: empty check");
`endif
  endtask

  int rv0, clr0, clren0;

  initial begin
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    byte_last  = 1'b0;
    abort      = 1'b0;
    #2 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy",         {31'h0, busy},         32'h0);
    check("rst_byte_ready",   {31'h0, byte_ready},   32'h0);
    check("rst_result",       {16'h0, result},       32'h0);
    check("rst_result_valid", {31'h0, result_valid}, 32'h0);
    check("rst_crc_enable",   {31'h0, crc_enable},   32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: gapless "123456789"
    en_total = 0; max_run = 0; rv0 = rv_count;
    exp_q.push_back(16'h29B1);
    send_msg(0);
    wait_result();
    check("t1_en_total", en_total, 72);
    check("t1_en_run",   max_run,  72);
    finish_frame(16'h29B1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("t1_rv_count", rv_count - rv0, 1);

    // 2: single 0x00 after 5 idle cycles
    repeat (5) @(posedge clk);
    #1;
    clr0 = clr_cnt; clren0 = clr_en_cnt;
    exp_q.push_back(16'hE1F0);
    send_byte(8'h00, 1'b1);
    wait_result();
`ifndef CRC_CHECK_EN
    @(negedge clk);
    check("t2_busy_after_done", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
`endif
    check("t2_clear_pulses",     clr_cnt - clr0,       1);
    check("t2_clear_then_enable", clr_en_cnt - clren0, 1);
    finish_frame(16'hE1F0, 1'b1);

    // 3: 3-cycle gaps between bytes
    repeat (2) @(posedge clk);
    #1;
    en_total = 0; max_run = 0;
    exp_q.push_back(16'h29B1);
    send_msg(3);
    wait_result();
    check("t3_en_total", en_total, 72);
    check("t3_en_run",   max_run,  8);
    finish_frame(16'h29B1, 1'b1);

    // 4: abort in the 4th byte's SHIFT, then a full frame
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send_byte(msg[i], 1'b0);
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("t4_busy_after_abort", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    exp_q.push_back(16'h29B1);
    send_msg(0);
    wait_result();
    finish_frame(16'h29B1, 1'b1);

    // 5: asynchronous reset mid-SHIFT, then a full frame
    repeat (2) @(posedge clk);
    #1;
    send_byte(msg[0], 1'b0);
    send_byte(msg[1], 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t5_busy",        {31'h0, busy},       32'h0);
    check("t5_crc_enable",  {31'h0, crc_enable}, 32'h0);
    check("t5_crc_serial",  {31'h0, crc_serial}, 32'h0);
    check("t5_byte_ready",  {31'h0, byte_ready}, 32'h0);
    check("t5_result",      {16'h0, result},     32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(16'h29B1);
    send_msg(0);
    wait_result();
    finish_frame(16'h29B1, 1'b1);

    // 6: abort held in IDLE while the first byte is accepted
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1;
    exp_q.push_back(16'hE1F0);
    send_byte(8'h00, 1'b1);
    abort = 1'b0;
    wait_result();
    finish_frame(16'hE1F0, 1'b1);

`ifdef CRC_CHECK_EN
    // 7: wrong received CRC
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(16'h29B1);
    send_msg(0);
    wait_result();
    finish_frame(16'h29B0, 1'b0);
`endif

    repeat (10) @(posedge clk);
    #1;
    check("result_queue_empty", exp_q.size(), 0);
    check("ok_queue_empty",     ok_q.size(),  0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
